// File: rtl/bus_rr_arbiter_if.sv
// Bus bundle between the arbiter, its masters and the single slave port.
// The "master" modport is the arbiter's side facing the bus masters; the
// "slave" modport is the arbiter's side facing the slave.
interface bus_rr_arbiter_if #(
    parameter int unsigned P_NUM_MASTERS = 4,
    parameter int unsigned P_ADDR_WIDTH  = 8,
    parameter int unsigned P_DATA_WIDTH  = 32
);
    logic [P_NUM_MASTERS-1:0]              m_req;
    logic [P_NUM_MASTERS*P_ADDR_WIDTH-1:0] m_addr;
    logic [P_NUM_MASTERS*P_DATA_WIDTH-1:0] m_wdata;
    logic [P_NUM_MASTERS-1:0]              m_write_en;
    logic [P_NUM_MASTERS-1:0]              m_gnt;
    logic [P_DATA_WIDTH-1:0]               m_rdata;
    logic                                  m_err;

    logic                                  s_req;
    logic [P_ADDR_WIDTH-1:0]               s_addr;
    logic [P_DATA_WIDTH-1:0]               s_wdata;
    logic                                  s_write_en;
    logic                                  s_gnt;
    logic [P_DATA_WIDTH-1:0]               s_rdata;

    modport master (
        input  m_req, m_addr, m_wdata, m_write_en,
        output m_gnt, m_rdata, m_err
    );

    modport slave (
        output s_req, s_addr, s_wdata, s_write_en,
        input  s_gnt, s_rdata
    );
endinterface

// File: rtl/bus_rr_arbiter.sv
// Round-robin N-master to 1-slave arbiter with a slave timeout that returns
// an error grant, plus a saturating timeout counter.
module bus_rr_arbiter #(
    parameter int unsigned P_NUM_MASTERS = 4,
    parameter int unsigned P_ADDR_WIDTH  = 8,
    parameter int unsigned P_DATA_WIDTH  = 32,
    parameter int unsigned P_TIMEOUT     = 3,
    parameter int unsigned P_CNT_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bus_rr_arbiter_if.master       mst,
    bus_rr_arbiter_if.slave        slv,
    output logic                   busy,
    output logic [P_CNT_WIDTH-1:0] err_cnt
);
    localparam int unsigned SelW = (P_NUM_MASTERS > 1) ? $clog2(P_NUM_MASTERS) : 1;

    typedef enum logic [1:0] {StIdle, StFwd, StResp} state_e;

    state_e                  state_q, state_d;
    logic [SelW-1:0]         sel_q, sel_d;
    logic [SelW-1:0]         last_q, last_d;
    logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [P_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                    we_q, we_d;
    logic [7:0]              wait_q, wait_d;
    logic [P_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic [P_CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;

    logic                    pick_valid;
    logic [SelW-1:0]         pick;
    int                      cand;

    // Round-robin pick: first requester at or after last_q+1, wrapping.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        cand       = 0;
        for (int k = 0; k < int'(P_NUM_MASTERS); k++) begin
            cand = (int'(last_q) + 1 + k) % int'(P_NUM_MASTERS);
            if (!pick_valid && mst.m_req[cand]) begin
                pick_valid = 1'b1;
                pick       = SelW'(cand);
            end
        end
    end

    // Next-state logic: latch the winner, forward to slave, then grant back.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        wait_d    = wait_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    sel_d   = pick;
                    addr_d  = mst.m_addr[32'(pick) * P_ADDR_WIDTH +: P_ADDR_WIDTH];
                    wdata_d = mst.m_wdata[32'(pick) * P_DATA_WIDTH +: P_DATA_WIDTH];
                    we_d    = mst.m_write_en[pick];
                    wait_d  = '0;
                    state_d = StFwd;
                end
            end
            StFwd: begin
                // A grant arriving on the timeout edge still wins.
                if (slv.s_gnt) begin
                    rdata_d = slv.s_rdata;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (wait_q == 8'(P_TIMEOUT)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    state_d = StResp;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StResp: begin
                last_d  = sel_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            sel_q     <= '0;
            last_q    <= SelW'(P_NUM_MASTERS - 1);
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            wait_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            wait_q    <= wait_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Outputs decoded from registers only; no input-to-output paths.
    always_comb begin
        slv.s_req      = (state_q == StFwd);
        slv.s_addr     = (state_q == StFwd) ? addr_q : '0;
        slv.s_wdata    = (state_q == StFwd) ? wdata_q : '0;
        slv.s_write_en = (state_q == StFwd) && we_q;
        mst.m_gnt      = '0;
        mst.m_rdata    = '0;
        mst.m_err      = 1'b0;
        if (state_q == StResp) begin
            mst.m_gnt[sel_q] = 1'b1;
            mst.m_rdata      = rdata_q;
            mst.m_err        = err_q;
        end
        busy = (state_q != StIdle);
    end

    assign err_cnt = err_cnt_q;
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: directed scenarios plus randomized rounds checked
// against a transaction-level round-robin / timeout model.
module tb_bus_rr_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned T  = 3;
    localparam int unsigned CW = 8;

    logic         clk;
    logic         rst_n;
    logic [CW-1:0] err_cnt;
    logic         busy;

    bus_rr_arbiter_if #(.P_NUM_MASTERS(N), .P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW)) bif ();

    bus_rr_arbiter #(
        .P_NUM_MASTERS(N),
        .P_ADDR_WIDTH (AW),
        .P_DATA_WIDTH (DW),
        .P_TIMEOUT    (T),
        .P_CNT_WIDTH  (CW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .mst    (bif),
        .slv    (bif),
        .busy   (busy),
        .err_cnt(err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1);
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Model state
    int         model_last;
    int         err_m;
    logic [AW-1:0] a_m [N];
    logic [DW-1:0] d_m [N];
    logic          w_m [N];

    // Slave responder controls
    int            slv_delay;
    logic [DW-1:0] slv_rdata;
    int            scnt;
    bit            late_mode;

    // Monitor captures
    bit            gnt_seen;
    logic [N-1:0]  gnt_val;
    logic [DW-1:0] rdata_g;
    logic          err_g;
    logic [CW-1:0] ecnt_g;
    int            sreq_cycles;
    logic [AW-1:0] s_addr_first;
    logic [DW-1:0] s_wdata_first;
    logic          s_we_first;
    bit            s_unstable;
    bit            overlap;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] mask, input int last);
        for (int k = 1; k <= int'(N); k++) begin
            if (mask[(last + k) % int'(N)]) return (last + k) % int'(N);
        end
        return -1;
    endfunction

    task automatic pack_fields();
        for (int i = 0; i < int'(N); i++) begin
            bif.m_addr[i*AW +: AW]  = a_m[i];
            bif.m_wdata[i*DW +: DW] = d_m[i];
            bif.m_write_en[i]       = w_m[i];
        end
    endtask

    task automatic set_fields();
        for (int i = 0; i < int'(N); i++) begin
            a_m[i] = AW'($urandom);
            d_m[i] = $urandom;
            w_m[i] = 1'($urandom);
        end
        pack_fields();
    endtask

    // One cycle: sample outputs at negedge, then drive the slave's response.
    task automatic tick();
        @(negedge clk);
        if (bif.s_req && (|bif.m_gnt)) overlap = 1'b1;
        if (bif.s_req) begin
            if (sreq_cycles == 0) begin
                s_addr_first  = bif.s_addr;
                s_wdata_first = bif.s_wdata;
                s_we_first    = bif.s_write_en;
            end else if (bif.s_addr !== s_addr_first || bif.s_wdata !== s_wdata_first ||
                         bif.s_write_en !== s_we_first) begin
                s_unstable = 1'b1;
            end
            sreq_cycles++;
        end
        if (|bif.m_gnt) begin
            gnt_seen = 1'b1;
            gnt_val  = bif.m_gnt;
            rdata_g  = bif.m_rdata;
            err_g    = bif.m_err;
            ecnt_g   = err_cnt;
        end
        if (bif.s_req) begin
            bif.s_gnt = (scnt == slv_delay);
            scnt++;
        end else begin
            scnt      = 0;
            bif.s_gnt = late_mode;
        end
        bif.s_rdata = slv_rdata;
    endtask

    // One arbitrated transaction from idle, checked against the model.
    task automatic do_round(input string tag, input logic [N-1:0] mask, input int delay,
                            input logic [DW-1:0] data);
        int win;
        int lat;
        int exp_sreq;
        bit exp_err;
        win      = rr_pick(mask, model_last);
        exp_err  = (delay > int'(T));
        exp_sreq = (exp_err ? int'(T) : delay) + 1;
        if (exp_err && err_m < 255) err_m++;
        slv_delay   = delay;
        slv_rdata   = data;
        late_mode   = 1'b0;
        sreq_cycles = 0;
        s_unstable  = 1'b0;
        gnt_seen    = 1'b0;
        gnt_val     = '0;
        bif.m_req   = mask;
        lat = 0;
        while (!gnt_seen && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_sreq + 1));
        check({tag, " gnt"}, 64'(gnt_val), 64'(1) << win);
        check({tag, " rdata"}, 64'(rdata_g), exp_err ? 64'(0) : 64'(data));
        check({tag, " err"}, 64'(err_g), 64'(exp_err));
        check({tag, " err_cnt"}, 64'(ecnt_g), 64'(err_m));
        check({tag, " sreq_cycles"}, 64'(sreq_cycles), 64'(exp_sreq));
        check({tag, " s_addr"}, 64'(s_addr_first), 64'(a_m[win]));
        check({tag, " s_wdata"}, 64'(s_wdata_first), 64'(d_m[win]));
        check({tag, " s_we"}, 64'(s_we_first), 64'(w_m[win]));
        check({tag, " s_stable"}, 64'(s_unstable), 64'(0));
        bif.m_req = '0;
        tick();
        check({tag, " gnt_1cycle"}, 64'(bif.m_gnt), 64'(0));
        check({tag, " idle"}, 64'(busy), 64'(0));
        model_last = win;
    endtask

    initial begin
        rst_n          = 1'b0;
        bif.m_req      = '0;
        bif.m_addr     = '0;
        bif.m_wdata    = '0;
        bif.m_write_en = '0;
        bif.s_gnt      = 1'b0;
        bif.s_rdata    = '0;
        model_last = int'(N) - 1;
        err_m      = 0;
        slv_delay  = 0;
        slv_rdata  = '0;
        scnt       = 0;
        late_mode  = 1'b0;
        overlap    = 1'b0;
        sreq_cycles = 0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'(0));
        check("reset s_req", 64'(bif.s_req), 64'(0));
        check("reset m_gnt", 64'(bif.m_gnt), 64'(0));
        check("reset m_rdata", 64'(bif.m_rdata), 64'(0));
        check("reset m_err", 64'(bif.m_err), 64'(0));
        check("reset err_cnt", 64'(err_cnt), 64'(0));
        rst_n = 1'b1;
        tick();

        // All four request together: grants 0,1,2,3 with one idle cycle between.
        set_fields();
        slv_delay = 0;
        gnt_seen  = 1'b0;
        bif.m_req = '1;
        for (int k = 0; k < int'(N); k++) begin
            int n;
            n = 0;
            gnt_seen = 1'b0;
            while (!gnt_seen && n < 40) begin
                tick();
                n++;
            end
            check($sformatf("all4 gnt%0d", k), 64'(gnt_val), 64'(1) << k);
            bif.m_req[k] = 1'b0;
            tick();
            check($sformatf("all4 idle%0d", k), 64'(busy), 64'(0));
            if (k < int'(N) - 1) begin
                tick();
                check($sformatf("all4 busy%0d", k), 64'(busy), 64'(1));
            end
        end
        model_last = int'(N) - 1;

        // Single read from master 1, slave grants immediately.
        set_fields();
        w_m[1] = 1'b0;
        pack_fields();
        do_round("t1", 4'b0010, 0, 32'hDEADBEEF);

        // Slave never grants: timeout error.
        set_fields();
        do_round("t3", 4'b0100, 100, 32'h0BADF00D);

        // Late slave grant while s_req is low is ignored.
        late_mode = 1'b1;
        repeat (3) tick();
        check("late busy", 64'(busy), 64'(0));
        check("late m_gnt", 64'(bif.m_gnt), 64'(0));
        check("late err_cnt", 64'(err_cnt), 64'(err_m));
        late_mode = 1'b0;
        tick();

        // Grant exactly on the timeout cycle succeeds.
        set_fields();
        do_round("t4", 4'b1000, int'(T), 32'hCAFEF00D);

        // Master 2 write with a 2-cycle slave stall.
        set_fields();
        a_m[2] = 8'h3C;
        d_m[2] = 32'h12345678;
        w_m[2] = 1'b1;
        pack_fields();
        do_round("t6", 4'b0100, 2, 32'h55AA55AA);

        // Randomized rounds.
        for (int r = 0; r < 40; r++) begin
            set_fields();
            do_round($sformatf("rnd%0d", r), N'($urandom_range(1, (1 << N) - 1)),
                     int'($urandom_range(0, 5)), $urandom);
        end

        // Asynchronous reset in the middle of a forward phase.
        set_fields();
        slv_delay   = 100;
        sreq_cycles = 0;
        bif.m_req   = 4'b0001;
        tick();
        tick();
        check("t5 pre s_req", 64'(bif.s_req), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("t5 s_req", 64'(bif.s_req), 64'(0));
        check("t5 busy", 64'(busy), 64'(0));
        check("t5 m_gnt", 64'(bif.m_gnt), 64'(0));
        check("t5 err_cnt", 64'(err_cnt), 64'(0));
        bif.m_req = '0;
        bif.s_gnt = 1'b0;
        scnt      = 0;
        @(negedge clk);
        rst_n      = 1'b1;
        model_last = int'(N) - 1;
        err_m      = 0;
        set_fields();
        do_round("t5 post", 4'b0101, 0, $urandom);

        // Saturation of the timeout counter.
        for (int r = 0; r < 300; r++) begin
            do_round($sformatf("sat%0d", r), N'($urandom_range(1, (1 << N) - 1)), 50, $urandom);
        end
        check("sat err_cnt", 64'(err_cnt), 64'(255));
        check("no s_req/m_gnt overlap", 64'(overlap), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
